disp_frame_seq: RTL and testbench

//   Parametrised frame sequencer feeding the 7-segment display mux. It replaces the
//   per-feature address counters (marquee frames, IM scan, RF scan) with one engine.

---
 rtl/disp_frame_seq_if.sv | 29 ++
 rtl/disp_frame_seq.sv | 195 +++++++++++++++++++
 tb/tb_disp_frame_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_frame_seq_if.sv
// Control and data bundle between the frame sequencer and its owner/memory.
// The master side drives the controls and the async-read data; the slave is the sequencer.
interface disp_frame_seq_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
) ();
    logic              en_i;
    logic              speed_i;
    logic [1:0]        mode_i;
    logic              pause_i;
    logic              step_i;
    logic              restart_i;
    logic [DATA_W-1:0] rdata_i;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] frame_o;
    logic              frame_vld_o;
    logic              done_o;
    logic [1:0]        state_o;

    modport master (
        output en_i, speed_i, mode_i, pause_i, step_i, restart_i, rdata_i,
        input  addr_o, frame_o, frame_vld_o, done_o, state_o
    );

    modport slave (
        input  en_i, speed_i, mode_i, pause_i, step_i, restart_i, rdata_i,
        output addr_o, frame_o, frame_vld_o, done_o, state_o
    );
endinterface

// File: rtl/disp_frame_seq.sv
// Frame sequencer for the 7-segment display mux: prescaler tick, loop/ping-pong/one-shot
// address walk with pause/step/restart, and a registered frame word from async-read memory.
module disp_frame_seq #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 19,
    parameter int ADDR_W   = 6,
    parameter int DIV_W    = 32,
    parameter int FAST_BIT = 25,
    parameter int SLOW_BIT = 27
) (
    input  logic             clk,
    input  logic             rstn,
    disp_frame_seq_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic [DIV_W-1:0]  presc_q, presc_d;
    logic              tick_bit_q, tick_bit_d;
    logic              step_q, step_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;
    logic [1:0]        state_q, state_d;
    logic              done_q, done_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] frame_q, frame_d;
    logic              vld_q, vld_d;

    logic              sel_bit_s;
    logic              tick_s;
    logic              step_edge_s;
    logic              adv_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              next_dir_s;
    logic              oneshot_end_s;

    // Prescaler, edge detectors and frame latch next-state.
    always_comb begin
        presc_d     = presc_q + DIV_W'(1);
        sel_bit_s   = bus.speed_i ? presc_q[SLOW_BIT] : presc_q[FAST_BIT];
        tick_bit_d  = sel_bit_s;
        tick_s      = sel_bit_s & ~tick_bit_q;
        step_d      = bus.step_i;
        step_edge_s = bus.step_i & ~step_q;
        vld_d       = load_q;
        if (load_q) begin
            frame_d = bus.rdata_i;
        end else begin
            frame_d = frame_q;
        end
    end

    // Address that the next advance would produce; dir 1 means walking down.
    always_comb begin
        next_addr_s   = addr_q;
        next_dir_s    = 1'b0;
        oneshot_end_s = 1'b0;
        case (bus.mode_i)
            2'b01: begin
                if (DEPTH == 1) begin
                    next_addr_s = ADDR_ZERO;
                    next_dir_s  = 1'b0;
                end else if (!dir_q) begin
                    if (addr_q == ADDR_LAST) begin
                        next_addr_s = addr_q - ADDR_ONE;
                        next_dir_s  = 1'b1;
                    end else begin
                        next_addr_s = addr_q + ADDR_ONE;
                        next_dir_s  = 1'b0;
                    end
                end else begin
                    if (addr_q == ADDR_ZERO) begin
                        next_addr_s = addr_q + ADDR_ONE;
                        next_dir_s  = 1'b0;
                    end else begin
                        next_addr_s = addr_q - ADDR_ONE;
                        next_dir_s  = 1'b1;
                    end
                end
            end
            2'b10: begin
                if (addr_q == ADDR_LAST) begin
                    oneshot_end_s = 1'b1;
                end else begin
                    next_addr_s = addr_q + ADDR_ONE;
                end
            end
            default: begin
                if (addr_q == ADDR_LAST) begin
                    next_addr_s = ADDR_ZERO;
                end else begin
                    next_addr_s = addr_q + ADDR_ONE;
                end
            end
        endcase
    end

    // Control FSM: restart beats disable, disable beats DONE hold, DONE beats pause.
    always_comb begin
        addr_d  = addr_q;
        dir_d   = dir_q;
        state_d = state_q;
        done_d  = done_q;
        load_d  = 1'b0;
        adv_s   = 1'b0;
        if (bus.restart_i) begin
            addr_d  = ADDR_ZERO;
            dir_d   = 1'b0;
            done_d  = 1'b0;
            state_d = bus.en_i ? ST_RUN : ST_IDLE;
            load_d  = 1'b1;
        end else if (!bus.en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    done_d  = 1'b0;
                    load_d  = 1'b1;
                end
                ST_RUN: begin
                    if (bus.pause_i) begin
                        state_d = ST_PAUSE;
                    end else begin
                        adv_s = tick_s;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause_i) begin
                        state_d = ST_RUN;
                    end else begin
                        adv_s = step_edge_s;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (adv_s) begin
                if (oneshot_end_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    addr_d = next_addr_s;
                    dir_d  = next_dir_s;
                    load_d = 1'b1;
                end
            end else begin
                addr_d = addr_d;
            end
        end
    end

    // State registers; reset discards any load in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q    <= {DIV_W{1'b0}};
            tick_bit_q <= 1'b0;
            step_q     <= 1'b0;
            addr_q     <= ADDR_ZERO;
            dir_q      <= 1'b0;
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            load_q     <= 1'b0;
            frame_q    <= {DATA_W{1'b0}};
            vld_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_bit_q <= tick_bit_d;
            step_q     <= step_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            state_q    <= state_d;
            done_q     <= done_d;
            load_q     <= load_d;
            frame_q    <= frame_d;
            vld_q      <= vld_d;
        end
    end

    assign bus.addr_o      = addr_q;
    assign bus.frame_o     = frame_q;
    assign bus.frame_vld_o = vld_q;
    assign bus.done_o      = done_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_disp_frame_seq.sv
// Self-checking bench for disp_frame_seq (DEPTH=4, FAST_BIT=1, SLOW_BIT=3); frame loads
// are checked through an expected/observed scoreboard with cycle stamps.
`timescale 1ns/1ps
module tb_disp_frame_seq;
    localparam int DATA_W   = 64;
    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 6;
    localparam int DIV_W    = 32;
    localparam int FAST_BIT = 1;
    localparam int SLOW_BIT = 3;
    localparam int BUDGET   = 40;
    localparam logic [DATA_W-1:0] WBASE = 64'h1111_0000_0000_0000;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [DATA_W-1:0] exp_w_q[$];
    logic [DATA_W-1:0] obs_w_q[$];
    int                exp_c_q[$];
    int                obs_c_q[$];

    disp_frame_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    disp_frame_seq #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .DIV_W(DIV_W), .FAST_BIT(FAST_BIT), .SLOW_BIT(SLOW_BIT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Async-read frame memory: word k = 64'h1111_0000_0000_000k.
    assign bus.rdata_i = WBASE | DATA_W'(bus.addr_o);

    always @(negedge clk) begin
        if (bus.frame_vld_o === 1'b1) begin
            obs_w_q.push_back(bus.frame_o);
            obs_c_q.push_back(cyc);
        end
    end

    function automatic logic [DATA_W-1:0] word(input int k);
        return WBASE | DATA_W'(k);
    endfunction

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic sb_clear();
        exp_w_q.delete(); exp_c_q.delete(); obs_w_q.delete(); obs_c_q.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        nclk(3);
        n_cmp++; if (bus.addr_o !== 6'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", bus.addr_o); end
        n_cmp++; if (bus.frame_o !== 64'd0) begin n_err++; $display("FAIL rst_frame: got %h want 0", bus.frame_o); end
        n_cmp++; if (bus.frame_vld_o !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %b want 0", bus.frame_vld_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.state_o !== 2'b00) begin n_err++; $display("FAIL rst_state: got %b want 00", bus.state_o); end
        rstn = 1'b1;
        nclk(3);
        n_cmp++; if (bus.state_o !== 2'b00) begin n_err++; $display("FAIL rst_idle_hold: got %b want 00", bus.state_o); end
        sb_clear();
    endtask

    task automatic test_loop();
        int seq [5];
        int c0, last_c, t;
        logic [ADDR_W-1:0] prev;
        logic [DATA_W-1:0] ew, ow;
        int ec, oc;
        seq = '{1, 2, 3, 0, 1};
        sb_clear();
        bus.mode_i = 2'b00;
        bus.en_i   = 1'b1;
        c0 = cyc;
        exp_w_q.push_back(word(0)); exp_c_q.push_back(c0 + 2);
        nclk(1);
        n_cmp++; if (bus.frame_o !== 64'd0) begin n_err++; $display("FAIL loop_pre_frame: got %h want 0", bus.frame_o); end
        n_cmp++; if (bus.state_o !== 2'b01) begin n_err++; $display("FAIL loop_run: got %b want 01", bus.state_o); end
        last_c = 0;
        for (int i = 0; i < 5; i++) begin
            prev = bus.addr_o; t = 0;
            while (bus.addr_o === prev && t < BUDGET) begin nclk(1); t++; end
            n_cmp++; if (bus.addr_o !== ADDR_W'(seq[i])) begin n_err++; $display("FAIL loop_addr%0d: got %0d want %0d", i, bus.addr_o, seq[i]); end
            if (i > 0) begin
                n_cmp++; if (cyc - last_c !== 4) begin n_err++; $display("FAIL loop_interval%0d: got %0d want 4", i, cyc - last_c); end
            end
            last_c = cyc;
            exp_w_q.push_back(word(seq[i])); exp_c_q.push_back(cyc + 1);
        end
        bus.en_i = 1'b0;
        nclk(4);
        n_cmp++; if (bus.state_o !== 2'b00) begin n_err++; $display("FAIL dis_state: got %b want 00", bus.state_o); end
        nclk(10);
        n_cmp++; if (bus.addr_o !== 6'd1) begin n_err++; $display("FAIL dis_addr_hold: got %0d want 1", bus.addr_o); end
        n_cmp++; if (bus.frame_o !== word(1)) begin n_err++; $display("FAIL dis_frame_hold: got %h want %h", bus.frame_o, word(1)); end
        n_cmp++; if (obs_w_q.size() !== exp_w_q.size()) begin n_err++; $display("FAIL loop_sb_count: got %0d want %0d", obs_w_q.size(), exp_w_q.size()); end
        while (exp_w_q.size() > 0 && obs_w_q.size() > 0) begin
            ew = exp_w_q.pop_front(); ec = exp_c_q.pop_front();
            ow = obs_w_q.pop_front(); oc = obs_c_q.pop_front();
            n_cmp++; if (ow !== ew || oc !== ec) begin n_err++; $display("FAIL loop_sb_frame: got %h@%0d want %h@%0d", ow, oc, ew, ec); end
        end
    endtask

    task automatic test_pingpong_reset();
        int seq [10];
        int t;
        logic [ADDR_W-1:0] prev;
        seq = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
        sb_clear();
        bus.mode_i = 2'b01; bus.en_i = 1'b1; bus.restart_i = 1'b1;
        nclk(1);
        bus.restart_i = 1'b0;
        n_cmp++; if (bus.addr_o !== 6'd0) begin n_err++; $display("FAIL pp_start: got %0d want 0", bus.addr_o); end
        for (int i = 0; i < 10; i++) begin
            prev = bus.addr_o; t = 0;
            while (bus.addr_o === prev && t < BUDGET) begin nclk(1); t++; end
            n_cmp++; if (bus.addr_o !== ADDR_W'(seq[i])) begin n_err++; $display("FAIL pp_addr%0d: got %0d want %0d", i, bus.addr_o, seq[i]); end
        end
        // Now at addr 2 walking down, with a frame load still in flight.
        rstn = 1'b0; bus.en_i = 1'b0;
        #1;
        n_cmp++; if (bus.addr_o !== 6'd0) begin n_err++; $display("FAIL mrst_addr: got %0d want 0", bus.addr_o); end
        n_cmp++; if (bus.state_o !== 2'b00) begin n_err++; $display("FAIL mrst_state: got %b want 00", bus.state_o); end
        n_cmp++; if (bus.frame_o !== 64'd0) begin n_err++; $display("FAIL mrst_frame: got %h want 0", bus.frame_o); end
        n_cmp++; if (bus.frame_vld_o !== 1'b0 || bus.done_o !== 1'b0) begin n_err++; $display("FAIL mrst_flags: got vld=%b done=%b want 0/0", bus.frame_vld_o, bus.done_o); end
        nclk(1);
        sb_clear();
        rstn = 1'b1;
        nclk(4);
        n_cmp++; if (obs_w_q.size() !== 0) begin n_err++; $display("FAIL mrst_no_load: got %0d loads want 0", obs_w_q.size()); end
        n_cmp++; if (bus.frame_o !== 64'd0) begin n_err++; $display("FAIL mrst_frame_after: got %h want 0", bus.frame_o); end
        bus.en_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prev = bus.addr_o; t = 0;
            while (bus.addr_o === prev && t < BUDGET) begin nclk(1); t++; end
            n_cmp++; if (bus.addr_o !== ADDR_W'(i + 1)) begin n_err++; $display("FAIL mrst_dir_up%0d: got %0d want %0d", i, bus.addr_o, i + 1); end
        end
        bus.en_i = 1'b0;
        nclk(3);
    endtask

    task automatic test_oneshot();
        int t, c0, ec, oc;
        logic [ADDR_W-1:0] prev;
        logic [DATA_W-1:0] ew, ow;
        bus.mode_i = 2'b10; bus.en_i = 1'b1; bus.restart_i = 1'b1;
        nclk(1);
        bus.restart_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            prev = bus.addr_o; t = 0;
            while (bus.addr_o === prev && t < BUDGET) begin nclk(1); t++; end
            n_cmp++; if (bus.addr_o !== ADDR_W'(i)) begin n_err++; $display("FAIL os_addr%0d: got %0d want %0d", i, bus.addr_o, i); end
        end
        nclk(6);
        n_cmp++; if (bus.state_o !== 2'b11) begin n_err++; $display("FAIL os_state: got %b want 11", bus.state_o); end
        n_cmp++; if (bus.done_o !== 1'b1) begin n_err++; $display("FAIL os_done: got %b want 1", bus.done_o); end
        nclk(10);
        n_cmp++; if (bus.addr_o !== 6'd3) begin n_err++; $display("FAIL os_hold: got %0d want 3", bus.addr_o); end
        sb_clear();
        c0 = cyc;
        bus.restart_i = 1'b1;
        exp_w_q.push_back(word(0)); exp_c_q.push_back(c0 + 2);
        nclk(1);
        bus.restart_i = 1'b0;
        n_cmp++; if (bus.addr_o !== 6'd0 || bus.done_o !== 1'b0 || bus.state_o !== 2'b01) begin
            n_err++; $display("FAIL os_restart: got addr=%0d done=%b state=%b want 0/0/01", bus.addr_o, bus.done_o, bus.state_o);
        end
        bus.en_i = 1'b0;
        nclk(4);
        n_cmp++; if (obs_w_q.size() !== exp_w_q.size()) begin n_err++; $display("FAIL os_sb_count: got %0d want %0d", obs_w_q.size(), exp_w_q.size()); end
        while (exp_w_q.size() > 0 && obs_w_q.size() > 0) begin
            ew = exp_w_q.pop_front(); ec = exp_c_q.pop_front();
            ow = obs_w_q.pop_front(); oc = obs_c_q.pop_front();
            n_cmp++; if (ow !== ew || oc !== ec) begin n_err++; $display("FAIL os_sb_frame: got %h@%0d want %h@%0d", ow, oc, ew, ec); end
        end
    endtask

    task automatic test_pause_step();
        int seq [3];
        int t, c0, ec, oc;
        logic [ADDR_W-1:0] prev;
        logic [DATA_W-1:0] ew, ow;
        seq = '{3, 0, 1};
        bus.mode_i = 2'b00; bus.en_i = 1'b1; bus.restart_i = 1'b1;
        nclk(1);
        bus.restart_i = 1'b0;
        t = 0;
        while (bus.addr_o !== 6'd2 && t < BUDGET) begin nclk(1); t++; end
        bus.pause_i = 1'b1;
        nclk(20);
        n_cmp++; if (bus.addr_o !== 6'd2) begin n_err++; $display("FAIL pause_hold: got %0d want 2", bus.addr_o); end
        n_cmp++; if (bus.state_o !== 2'b10) begin n_err++; $display("FAIL pause_state: got %b want 10", bus.state_o); end
        sb_clear();
        for (int i = 0; i < 3; i++) begin
            c0 = cyc;
            bus.step_i = 1'b1;
            exp_w_q.push_back(word(seq[i])); exp_c_q.push_back(c0 + 2);
            nclk(5);
            n_cmp++; if (bus.addr_o !== ADDR_W'(seq[i])) begin n_err++; $display("FAIL step%0d: got %0d want %0d", i, bus.addr_o, seq[i]); end
            bus.step_i = 1'b0;
            nclk(3);
        end
        n_cmp++; if (obs_w_q.size() !== exp_w_q.size()) begin n_err++; $display("FAIL step_sb_count: got %0d want %0d", obs_w_q.size(), exp_w_q.size()); end
        while (exp_w_q.size() > 0 && obs_w_q.size() > 0) begin
            ew = exp_w_q.pop_front(); ec = exp_c_q.pop_front();
            ow = obs_w_q.pop_front(); oc = obs_c_q.pop_front();
            n_cmp++; if (ow !== ew || oc !== ec) begin n_err++; $display("FAIL step_sb_frame: got %h@%0d want %h@%0d", ow, oc, ew, ec); end
        end
        bus.pause_i = 1'b0;
        prev = bus.addr_o; t = 0;
        while (bus.addr_o === prev && t < BUDGET) begin nclk(1); t++; end
        n_cmp++; if (bus.addr_o !== 6'd2) begin n_err++; $display("FAIL unpause_addr: got %0d want 2", bus.addr_o); end
        bus.step_i = 1'b1;
        nclk(3);
        n_cmp++; if (bus.addr_o !== 6'd2) begin n_err++; $display("FAIL step_in_run: got %0d want 2", bus.addr_o); end
        bus.step_i = 1'b0; bus.en_i = 1'b0;
        nclk(3);
    endtask

    task automatic test_speed();
        int t, c1;
        logic [ADDR_W-1:0] prev;
        bus.speed_i = 1'b1; bus.mode_i = 2'b00; bus.en_i = 1'b1; bus.restart_i = 1'b1;
        nclk(1);
        bus.restart_i = 1'b0;
        c1 = 0;
        for (int i = 0; i < 3; i++) begin
            prev = bus.addr_o; t = 0;
            while (bus.addr_o === prev && t < BUDGET) begin nclk(1); t++; end
            if (i == 2) begin
                n_cmp++; if (cyc - c1 !== 16) begin n_err++; $display("FAIL slow_interval: got %0d want 16", cyc - c1); end
            end
            c1 = cyc;
        end
        bus.en_i = 1'b0; bus.speed_i = 1'b0;
        nclk(3);
    endtask

    initial begin
        rstn          = 1'b0;
        bus.en_i      = 1'b0;
        bus.speed_i   = 1'b0;
        bus.mode_i    = 2'b00;
        bus.pause_i   = 1'b0;
        bus.step_i    = 1'b0;
        bus.restart_i = 1'b0;
        test_reset();
        test_loop();
        test_pingpong_reset();
        test_oneshot();
        test_pause_step();
        test_speed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
